// File: rtl/c6_pkg.sv
// Board constants, FSM state and error encodings shared by the Connect6 sequencer.
package c6_pkg;
    localparam int BOARD_SIZE = 19;
    localparam int COORD_W    = 5;
    localparam int NUM_CELLS  = BOARD_SIZE * BOARD_SIZE;
    localparam int IDX_W      = 9;
    localparam int STONES_W   = 9;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [3:0] {
        IDLE, CLEAR, WAIT_OPP, CHECK, WR_OPP1, WR_OPP2,
        ENG_START, ENG_WAIT, WR_OUR, OUTPUT, DONE, ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE, ERR_OPP, ERR_ENG, ERR_TIMEOUT
    } err_t;

    function automatic logic on_board(coord_t x, coord_t y);
        return (x < coord_t'(BOARD_SIZE)) && (y < coord_t'(BOARD_SIZE));
    endfunction

    // Row-major cell index; only meaningful when on_board() holds.
    function automatic logic [IDX_W-1:0] cell_idx(coord_t x, coord_t y);
        return IDX_W'(y) * IDX_W'(BOARD_SIZE) + IDX_W'(x);
    endfunction
endpackage

// File: rtl/c6_occupancy_map.sv
// One bit per board cell: synchronous clear, one set port, two lookup ports.
module c6_occupancy_map
    import c6_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               set_i,
    input  logic [COORD_W-1:0] set_x_i,
    input  logic [COORD_W-1:0] set_y_i,
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    output logic               a_occ_o,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic               b_occ_o
);
    logic [NUM_CELLS-1:0] map_q;
    logic [NUM_CELLS-1:0] map_d;

    always_comb begin
        map_d = map_q;
        if (clr_i) begin
            map_d = '0;
        end else if (set_i && on_board(set_x_i, set_y_i)) begin
            map_d[cell_idx(set_x_i, set_y_i)] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    // Off-board coordinates read as free; the caller rejects them separately.
    assign a_occ_o = on_board(a_x_i, a_y_i) && map_q[cell_idx(a_x_i, a_y_i)];
    assign b_occ_o = on_board(b_x_i, b_y_i) && map_q[cell_idx(b_x_i, b_y_i)];
endmodule

// File: rtl/c6_turn_sequencer.sv
// Connect6 turn sequencer: opponent intake and legality check, board writes,
// engine stepping with timeout, and presentation of our stone pair.
module c6_turn_sequencer
    import c6_pkg::*;
#(
    parameter int ENG_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               we_first,
    input  logic               opp_valid,
    output logic               opp_ready,
    input  logic [COORD_W-1:0] opp_x1,
    input  logic [COORD_W-1:0] opp_y1,
    input  logic [COORD_W-1:0] opp_x2,
    input  logic [COORD_W-1:0] opp_y2,
    input  logic               opp_single,
    output logic               bw_en,
    output logic [COORD_W-1:0] bw_x,
    output logic [COORD_W-1:0] bw_y,
    output logic               bw_owner,
    output logic               bw_clear,
    input  logic               bw_clear_done,
    output logic               eng_start,
    output logic [1:0]         eng_moves_left,
    input  logic               eng_done,
    input  logic [COORD_W-1:0] eng_x,
    input  logic [COORD_W-1:0] eng_y,
    output logic               our_valid,
    input  logic               our_ready,
    output logic [COORD_W-1:0] our_x1,
    output logic [COORD_W-1:0] our_y1,
    output logic [COORD_W-1:0] our_x2,
    output logic [COORD_W-1:0] our_y2,
    output logic               our_single,
    output logic               busy,
    output logic               game_over,
    output logic [1:0]         err,
    output logic [8:0]         stones
);
    localparam int TMO_W = $clog2(ENG_TIMEOUT + 1);

    state_t              state_q, state_d;
    err_t                err_q, err_d;
    logic                we_first_q, we_first_d;
    logic [COORD_W-1:0]  ox1_q, oy1_q, ox2_q, oy2_q, ox1_d, oy1_d, ox2_d, oy2_d;
    logic                osingle_q, osingle_d;
    logic [COORD_W-1:0]  cur_x_q, cur_y_q, cur_x_d, cur_y_d;
    logic [COORD_W-1:0]  our_x1_q, our_y1_q, our_x2_q, our_y2_q;
    logic [COORD_W-1:0]  our_x1_d, our_y1_d, our_x2_d, our_y2_d;
    logic                our_single_q, our_single_d, second_q, second_d;
    logic [1:0]          moves_q, moves_d;
    logic [STONES_W-1:0] stones_q, stones_d, stones_inc, remain;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                occ_a, occ_b, map_clr, reject;
    logic [COORD_W-1:0]  look_x, look_y;

    // Port A serves the engine stone in ENG_WAIT and opponent stone 1 in CHECK.
    assign look_x = (state_q == ENG_WAIT) ? eng_x : ox1_q;
    assign look_y = (state_q == ENG_WAIT) ? eng_y : oy1_q;

    c6_occupancy_map u_map (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (map_clr),
        .set_i   (bw_en),
        .set_x_i (bw_x),
        .set_y_i (bw_y),
        .a_x_i   (look_x),
        .a_y_i   (look_y),
        .a_occ_o (occ_a),
        .b_x_i   (ox2_q),
        .b_y_i   (oy2_q),
        .b_occ_o (occ_b)
    );

    assign stones_inc = stones_q + STONES_W'(1);
    assign remain     = STONES_W'(NUM_CELLS) - stones_inc;
    assign reject     = !on_board(ox1_q, oy1_q) || occ_a ||
                        (!osingle_q && (!on_board(ox2_q, oy2_q) || occ_b ||
                                        (ox1_q == ox2_q && oy1_q == oy2_q)));

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        we_first_d   = we_first_q;
        ox1_d        = ox1_q;
        oy1_d        = oy1_q;
        ox2_d        = ox2_q;
        oy2_d        = oy2_q;
        osingle_d    = osingle_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        our_x1_d     = our_x1_q;
        our_y1_d     = our_y1_q;
        our_x2_d     = our_x2_q;
        our_y2_d     = our_y2_q;
        our_single_d = our_single_q;
        second_d     = second_q;
        moves_d      = moves_q;
        stones_d     = stones_q;
        tmo_d        = tmo_q;
        opp_ready    = 1'b0;
        bw_en        = 1'b0;
        bw_x         = '0;
        bw_y         = '0;
        bw_owner     = 1'b0;
        bw_clear     = 1'b0;
        eng_start    = 1'b0;
        map_clr      = 1'b0;

        case (state_q)
            CLEAR: begin
                bw_clear = 1'b1;
                map_clr  = 1'b1;
                stones_d = '0;
                if (bw_clear_done) begin
                    if (we_first_q) begin
                        moves_d      = 2'd1;
                        our_single_d = 1'b1;
                        second_d     = 1'b0;
                        state_d      = ENG_START;
                    end else begin
                        state_d = WAIT_OPP;
                    end
                end
            end
            WAIT_OPP: begin
                opp_ready = 1'b1;
                if (opp_valid) begin
                    ox1_d     = opp_x1;
                    oy1_d     = opp_y1;
                    ox2_d     = opp_x2;
                    oy2_d     = opp_y2;
                    osingle_d = opp_single;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    err_d   = ERR_OPP;
                    state_d = WAIT_OPP;
                end else begin
                    err_d   = ERR_NONE;
                    state_d = WR_OPP1;
                end
            end
            WR_OPP1: begin
                bw_en    = 1'b1;
                bw_x     = ox1_q;
                bw_y     = oy1_q;
                stones_d = stones_inc;
                state_d  = WR_OPP2;
            end
            WR_OPP2: begin
                bw_en    = 1'b1;
                bw_x     = ox2_q;
                bw_y     = oy2_q;
                stones_d = stones_inc;
            end
            ENG_START: begin
                eng_start = 1'b1;
                tmo_d     = TMO_W'(ENG_TIMEOUT - 1);
                state_d   = ENG_WAIT;
            end
            ENG_WAIT: begin
                // A legal answer on the expiry cycle still counts.
                if (eng_done) begin
                    if (!on_board(eng_x, eng_y) || occ_a) begin
                        err_d   = ERR_ENG;
                        state_d = ERROR;
                    end else begin
                        cur_x_d = eng_x;
                        cur_y_d = eng_y;
                        if (second_q) begin
                            our_x2_d = eng_x;
                            our_y2_d = eng_y;
                        end else begin
                            our_x1_d = eng_x;
                            our_y1_d = eng_y;
                        end
                        state_d = WR_OUR;
                    end
                end else if (tmo_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            WR_OUR: begin
                bw_en    = 1'b1;
                bw_x     = cur_x_q;
                bw_y     = cur_y_q;
                bw_owner = 1'b1;
                stones_d = stones_inc;
                moves_d  = moves_q - 2'd1;
                second_d = 1'b1;
                state_d  = (moves_q == 2'd1) ? OUTPUT : ENG_START;
            end
            OUTPUT: begin
                if (our_ready) begin
                    state_d = (stones_q == STONES_W'(NUM_CELLS)) ? DONE : WAIT_OPP;
                end
            end
            default: ;
        endcase

        // Last opponent stone written: either the board is full or our turn begins.
        if ((state_q == WR_OPP1 && osingle_q) || state_q == WR_OPP2) begin
            if (stones_inc == STONES_W'(NUM_CELLS)) begin
                state_d = DONE;
            end else begin
                moves_d      = (remain >= STONES_W'(2)) ? 2'd2 : 2'd1;
                our_single_d = (remain == STONES_W'(1));
                second_d     = 1'b0;
                our_x1_d     = '0;
                our_y1_d     = '0;
                our_x2_d     = '0;
                our_y2_d     = '0;
                state_d      = ENG_START;
            end
        end

        if (start) begin
            state_d      = CLEAR;
            we_first_d   = we_first;
            err_d        = ERR_NONE;
            moves_d      = 2'd0;
            stones_d     = '0;
            our_x1_d     = '0;
            our_y1_d     = '0;
            our_x2_d     = '0;
            our_y2_d     = '0;
            our_single_d = 1'b0;
            second_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            err_q        <= ERR_NONE;
            we_first_q   <= 1'b0;
            ox1_q        <= '0;
            oy1_q        <= '0;
            ox2_q        <= '0;
            oy2_q        <= '0;
            osingle_q    <= 1'b0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            our_x1_q     <= '0;
            our_y1_q     <= '0;
            our_x2_q     <= '0;
            our_y2_q     <= '0;
            our_single_q <= 1'b0;
            second_q     <= 1'b0;
            moves_q      <= 2'd0;
            stones_q     <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            we_first_q   <= we_first_d;
            ox1_q        <= ox1_d;
            oy1_q        <= oy1_d;
            ox2_q        <= ox2_d;
            oy2_q        <= oy2_d;
            osingle_q    <= osingle_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            our_x1_q     <= our_x1_d;
            our_y1_q     <= our_y1_d;
            our_x2_q     <= our_x2_d;
            our_y2_q     <= our_y2_d;
            our_single_q <= our_single_d;
            second_q     <= second_d;
            moves_q      <= moves_d;
            stones_q     <= stones_d;
            tmo_q        <= tmo_d;
        end
    end

    assign our_valid      = (state_q == OUTPUT);
    assign busy           = !(state_q == IDLE || state_q == WAIT_OPP || state_q == DONE);
    assign game_over      = (state_q == DONE);
    assign err            = err_q;
    assign stones         = stones_q;
    assign eng_moves_left = moves_q;
    assign our_x1         = our_x1_q;
    assign our_y1         = our_y1_q;
    assign our_x2         = our_x2_q;
    assign our_y2         = our_y2_q;
    assign our_single     = our_single_q;
endmodule

// File: tb/tb_c6_turn_sequencer.sv
// Directed bench for c6_turn_sequencer with a board-level model and a per-cycle write/stone checker.
module tb_c6_turn_sequencer;
    import c6_pkg::*;

    logic clk = 1'b0;
    logic reset, start, we_first;
    logic opp_valid, opp_ready, opp_single;
    logic [COORD_W-1:0] opp_x1, opp_y1, opp_x2, opp_y2;
    logic bw_en, bw_owner, bw_clear, bw_clear_done;
    logic [COORD_W-1:0] bw_x, bw_y;
    logic eng_start, eng_done;
    logic [1:0] eng_moves_left;
    logic [COORD_W-1:0] eng_x, eng_y;
    logic our_valid, our_ready, our_single;
    logic [COORD_W-1:0] our_x1, our_y1, our_x2, our_y2;
    logic busy, game_over;
    logic [1:0] err;
    logic [8:0] stones;

    always #5 clk = ~clk;

    c6_turn_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .we_first(we_first),
        .opp_valid(opp_valid), .opp_ready(opp_ready),
        .opp_x1(opp_x1), .opp_y1(opp_y1), .opp_x2(opp_x2), .opp_y2(opp_y2),
        .opp_single(opp_single),
        .bw_en(bw_en), .bw_x(bw_x), .bw_y(bw_y), .bw_owner(bw_owner),
        .bw_clear(bw_clear), .bw_clear_done(bw_clear_done),
        .eng_start(eng_start), .eng_moves_left(eng_moves_left),
        .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
        .our_valid(our_valid), .our_ready(our_ready),
        .our_x1(our_x1), .our_y1(our_y1), .our_x2(our_x2), .our_y2(our_y2),
        .our_single(our_single),
        .busy(busy), .game_over(game_over), .err(err), .stones(stones)
    );

    int total = 0;
    int bad = 0;

    // Board model: who sits where, how many stones, which writes must appear next.
    bit occ_m [NUM_CELLS];
    int mdl_stones;
    int cmp_stones;
    bit cmp_on = 1'b0;
    typedef struct { int x; int y; int owner; } wr_t;
    wr_t wq[$];
    wr_t cw;
    int ex1, ey1, ex2, ey2, esingle, turn_idx;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cell_free(input int x, input int y);
        if (x < 0 || x >= BOARD_SIZE || y < 0 || y >= BOARD_SIZE) return 1'b0;
        return !occ_m[y * BOARD_SIZE + x];
    endfunction

    task automatic place(input int x, input int y, input int owner);
        wr_t w;
        occ_m[y * BOARD_SIZE + x] = 1'b1;
        mdl_stones++;
        w.x = x; w.y = y; w.owner = owner;
        wq.push_back(w);
    endtask

    task automatic model_clear();
        foreach (occ_m[i]) occ_m[i] = 1'b0;
        mdl_stones = 0;
        cmp_stones = 0;
        wq.delete();
        ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0; turn_idx = 0; esingle = 0;
    endtask

    // Every board write must be the next one the model expects; stones must track the writes.
    always @(negedge clk) begin
        if (cmp_on && !reset) begin
            check("stones_track", int'(stones), cmp_stones);
            check("ready_and_valid", int'(opp_ready & our_valid), 0);
            if (bw_en) begin
                if (wq.size() == 0) begin
                    check("bw_unexpected", int'(bw_en), 0);
                end else begin
                    cw = wq.pop_front();
                    check("bw_x", int'(bw_x), cw.x);
                    check("bw_y", int'(bw_y), cw.y);
                    check("bw_owner", int'(bw_owner), cw.owner);
                end
                cmp_stones++;
            end
        end
    end

    task automatic do_start(input bit wf);
        start = 1'b1; we_first = wf;
        tick();
        start = 1'b0;
        model_clear();
        esingle = int'(wf);
        check("start_bw_clear", int'(bw_clear), 1);
        check("start_our_valid", int'(our_valid), 0);
        check("start_err", int'(err), 0);
        check("start_our_x1", int'(our_x1), 0);
        bw_clear_done = 1'b1;
        tick();
        bw_clear_done = 1'b0;
    endtask

    task automatic send_opp(input int x1, input int y1, input int x2, input int y2, input bit single);
        int n;
        bit legal;
        n = 0;
        while (!opp_ready && n < 50) begin tick(); n++; end
        check("opp_ready_wait", int'(opp_ready), 1);
        opp_valid = 1'b1; opp_single = single;
        opp_x1 = COORD_W'(x1); opp_y1 = COORD_W'(y1);
        opp_x2 = COORD_W'(x2); opp_y2 = COORD_W'(y2);
        tick();
        opp_valid = 1'b0;
        check("check_ready_low", int'(opp_ready), 0);
        legal = cell_free(x1, y1) && (single || (cell_free(x2, y2) && !(x1 == x2 && y1 == y2)));
        tick();
        if (!legal) begin
            check("reject_err", int'(err), 1);
            check("reject_ready_back", int'(opp_ready), 1);
            check("reject_no_bw", int'(bw_en), 0);
        end else begin
            place(x1, y1, 0);
            check("accept_err", int'(err), 0);
            check("opp_wr1", int'(bw_en), 1);
            if (!single) begin
                place(x2, y2, 0);
                tick();
                check("opp_wr2", int'(bw_en), 1);
            end
            tick();
            if (mdl_stones == NUM_CELLS) begin
                check("opp_fill_done", int'(game_over), 1);
            end else begin
                check("eng_start_latency", int'(eng_start), 1);
                check("turn_moves_left", int'(eng_moves_left), (NUM_CELLS - mdl_stones >= 2) ? 2 : 1);
            end
            turn_idx = 0;
            esingle = (NUM_CELLS - mdl_stones == 1) ? 1 : 0;
            ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0;
        end
    endtask

    task automatic eng_stone(input int x, input int y, input int ml, input bit last);
        int n;
        n = 0;
        while (!eng_start && n < 50) begin tick(); n++; end
        check("eng_start_seen", int'(eng_start), 1);
        check("eng_moves_left", int'(eng_moves_left), ml);
        tick();
        tick();
        eng_done = 1'b1; eng_x = COORD_W'(x); eng_y = COORD_W'(y);
        tick();
        eng_done = 1'b0;
        if (cell_free(x, y)) begin
            place(x, y, 1);
            if (turn_idx == 0) begin ex1 = x; ey1 = y; end
            else begin ex2 = x; ey2 = y; end
            turn_idx++;
            check("eng_wr", int'(bw_en), 1);
            tick();
            if (last) check("our_valid_rise", int'(our_valid), 1);
            else check("eng_start_next", int'(eng_start), 1);
        end else begin
            check("eng_illegal_err", int'(err), 2);
            check("eng_illegal_busy", int'(busy), 1);
        end
    endtask

    task automatic take_our();
        check("our_valid", int'(our_valid), 1);
        check("our_x1", int'(our_x1), ex1);
        check("our_y1", int'(our_y1), ey1);
        check("our_x2", int'(our_x2), ex2);
        check("our_y2", int'(our_y2), ey2);
        check("our_single", int'(our_single), esingle);
        tick();
        check("our_valid_held", int'(our_valid), 1);
        our_ready = 1'b1;
        tick();
        our_ready = 1'b0;
        check("our_valid_drop", int'(our_valid), 0);
        if (mdl_stones == NUM_CELLS) check("game_over", int'(game_over), 1);
        else check("opp_ready_after_out", int'(opp_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, stones=%0d", stones);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; start = 1'b0; we_first = 1'b0;
        opp_valid = 1'b0; opp_single = 1'b0;
        opp_x1 = '0; opp_y1 = '0; opp_x2 = '0; opp_y2 = '0;
        bw_clear_done = 1'b0; eng_done = 1'b0; eng_x = '0; eng_y = '0; our_ready = 1'b0;
        model_clear();
        repeat (3) tick();
        check("rst_opp_ready", int'(opp_ready), 0);
        check("rst_bw_en", int'(bw_en), 0);
        check("rst_bw_clear", int'(bw_clear), 0);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_our_valid", int'(our_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_err", int'(err), 0);
        check("rst_stones", int'(stones), 0);
        check("rst_moves_left", int'(eng_moves_left), 0);
        reset = 1'b0;
        tick();
        cmp_on = 1'b1;
        check("idle_busy", int'(busy), 0);
        check("idle_opp_ready", int'(opp_ready), 0);

        // Opponent opening, with a stray eng_done that must be ignored.
        do_start(1'b0);
        eng_done = 1'b1; eng_x = 5'd1; eng_y = 5'd1;
        tick();
        eng_done = 1'b0;
        send_opp(9, 9, 0, 0, 1'b1);
        eng_stone(8, 8, 2, 1'b0);
        eng_stone(10, 10, 1, 1'b1);
        check("t1_lit_x1", int'(our_x1), 8);
        check("t1_lit_x2", int'(our_x2), 10);
        check("t1_lit_y2", int'(our_y2), 10);
        take_our();
        check("t1_lit_stones", int'(stones), 3);

        // We open with a single stone.
        do_start(1'b1);
        check("t2_moves_left", int'(eng_moves_left), 1);
        eng_stone(9, 9, 1, 1'b1);
        check("t2_lit_single", int'(our_single), 1);
        take_our();

        // Illegal opponent moves, then an accepted resend.
        send_opp(3, 3, 3, 3, 1'b0);
        send_opp(19, 0, 5, 5, 1'b0);
        send_opp(9, 9, 1, 1, 1'b0);
        send_opp(3, 3, 4, 4, 1'b0);
        eng_stone(5, 5, 2, 1'b0);
        eng_stone(6, 6, 1, 1'b1);
        take_our();
        check("t3_lit_stones", int'(stones), 5);

        // Engine answers an occupied cell.
        send_opp(10, 10, 11, 11, 1'b0);
        eng_stone(3, 3, 2, 1'b0);
        repeat (3) tick();
        check("t4_err_hold", int'(err), 2);
        check("t4_no_eng_start", int'(eng_start), 0);
        check("t4_busy", int'(busy), 1);

        // Engine never answers.
        do_start(1'b0);
        send_opp(0, 0, 0, 0, 1'b1);
        repeat (4096) tick();
        check("t5_err_before_expiry", int'(err), 0);
        tick();
        check("t5_err_timeout", int'(err), 3);
        check("t5_busy", int'(busy), 1);

        // Start in OUTPUT, then reset in ENG_WAIT.
        do_start(1'b1);
        eng_stone(0, 0, 1, 1'b1);
        do_start(1'b0);
        send_opp(1, 1, 2, 2, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("t6_rst_bw_en", int'(bw_en), 0);
        check("t6_rst_eng_start", int'(eng_start), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_stones", int'(stones), 0);
        check("t6_rst_moves_left", int'(eng_moves_left), 0);
        check("t6_rst_our_x1", int'(our_x1), 0);
        check("t6_rst_err", int'(err), 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6_idle_ready", int'(opp_ready), 0);

        // Fill the board: cells used in row-major order.
        do_start(1'b0);
        send_opp(0, 0, 0, 0, 1'b1);
        eng_stone(1, 0, 2, 1'b0);
        eng_stone(2, 0, 1, 1'b1);
        take_our();
        for (int r = 0; r < 89; r++) begin
            c = 3 + 4 * r;
            send_opp(c % 19, c / 19, (c + 1) % 19, (c + 1) / 19, 1'b0);
            eng_stone((c + 2) % 19, (c + 2) / 19, 2, 1'b0);
            eng_stone((c + 3) % 19, (c + 3) / 19, 1, 1'b1);
            take_our();
        end
        check("t7_lit_359", int'(stones), 359);
        send_opp(359 % 19, 359 / 19, 0, 0, 1'b1);
        check("t7_lit_moves_left", int'(eng_moves_left), 1);
        eng_stone(360 % 19, 360 / 19, 1, 1'b1);
        check("t7_lit_single", int'(our_single), 1);
        check("t7_over_before_ready", int'(game_over), 0);
        take_our();
        check("t7_lit_361", int'(stones), 361);
        check("t7_lit_game_over", int'(game_over), 1);
        check("t7_not_busy", int'(busy), 0);

        tick();
        check("pending_writes", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
